rf_access_ctrl: RTL and testbench

RF_ACCESS_CTRL -- requirements
Module: rf_access_ctrl

---
 rtl/rf_access_ctrl_pkg.sv | 28 ++
 rtl/rf_access_ctrl_if.sv | 46 ++++
 rtl/rf_access_ctrl.sv | 111 +++++++++++
 tb/tb_rf_access_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_access_ctrl_pkg.sv
// Shared definitions for the register-file access controller.
// Widths, FSM state encoding and the read-only zero-register address.
// Imported by the interface and the controller.
package rf_access_ctrl_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [REG_ADDR_W-1:0] raddr_t;

  // Register 0 always reads as zero, so writes to it are dropped.
  localparam raddr_t ZERO_REG = '0;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_ISSUE = 3'd1,
    ST_RD_CAPT  = 3'd2,
    ST_RD_DONE  = 3'd3,
    ST_WR_ISSUE = 3'd4,
    ST_WR_DONE  = 3'd5
  } state_t;

  function automatic logic is_zero_reg(input raddr_t a);
    return a == ZERO_REG;
  endfunction

endpackage

// File: rtl/rf_access_ctrl_if.sv
// Bundle between the requester/register file and the access controller.
// Requester side: op_req/rs*_addr -> opnd*/opnd_valid, wb_req/wb_* -> wb_ack, busy.
// RF side: rf_read/rf_write strobes, latched addresses/data, rf_data_r* read back.
interface rf_access_ctrl_if;
  import rf_access_ctrl_pkg::*;

  // requester channel
  logic   op_req;
  raddr_t rs1_addr;
  raddr_t rs2_addr;
  data_t  opnd1;
  data_t  opnd2;
  logic   opnd_valid;
  logic   wb_req;
  raddr_t wb_addr;
  data_t  wb_data;
  logic   wb_ack;
  logic   busy;

  // register-file channel
  logic   rf_read;
  logic   rf_write;
  raddr_t rf_addr_r1;
  raddr_t rf_addr_r2;
  raddr_t rf_addr_w;
  data_t  rf_data_w;
  data_t  rf_data_r1;
  data_t  rf_data_r2;

  // environment: requester plus register file
  modport master (
    output op_req, rs1_addr, rs2_addr, wb_req, wb_addr, wb_data,
    output rf_data_r1, rf_data_r2,
    input  opnd1, opnd2, opnd_valid, wb_ack, busy,
    input  rf_read, rf_write, rf_addr_r1, rf_addr_r2, rf_addr_w, rf_data_w
  );

  // the controller
  modport slave (
    input  op_req, rs1_addr, rs2_addr, wb_req, wb_addr, wb_data,
    input  rf_data_r1, rf_data_r2,
    output opnd1, opnd2, opnd_valid, wb_ack, busy,
    output rf_read, rf_write, rf_addr_r1, rf_addr_r2, rf_addr_w, rf_data_w
  );

endinterface

// File: rtl/rf_access_ctrl.sv
// Purpose: sequences operand fetches and writebacks against a 2R/1W register file.
// Latency: fetch -> opnd_valid 3 cycles after acceptance; writeback -> wb_ack 2 cycles.
// Backpressure: requests only sampled in IDLE (busy=0); requests during busy are dropped, not queued.
// Ports: clk, rst_n (async active-low), bus (rf_access_ctrl_if.slave).
module rf_access_ctrl
  import rf_access_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  rf_access_ctrl_if.slave    bus
);

  state_t state_q, state_d;
  raddr_t rs1_q, rs1_d;
  raddr_t rs2_q, rs2_d;
  raddr_t wa_q, wa_d;
  data_t  wd_q, wd_d;
  data_t  opnd1_q, opnd1_d;
  data_t  opnd2_q, opnd2_d;
  logic   rf_read_q, rf_read_d;
  logic   rf_write_q, rf_write_d;
  logic   opnd_valid_q, opnd_valid_d;
  logic   wb_ack_q, wb_ack_d;
  logic   busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    wa_d    = wa_q;
    wd_d    = wd_q;
    opnd1_d = opnd1_q;
    opnd2_d = opnd2_q;

    unique case (state_q)
      ST_IDLE: begin
        // Writeback wins so a same-cycle fetch sees the new value.
        if (bus.wb_req) begin
          wa_d    = bus.wb_addr;
          wd_d    = bus.wb_data;
          state_d = ST_WR_ISSUE;
        end else if (bus.op_req) begin
          rs1_d   = bus.rs1_addr;
          rs2_d   = bus.rs2_addr;
          state_d = ST_RD_ISSUE;
        end
      end
      ST_RD_ISSUE: state_d = ST_RD_CAPT;
      ST_RD_CAPT: begin
        // Only point where RF read data is sampled; outside it the bus may float.
        opnd1_d = bus.rf_data_r1;
        opnd2_d = bus.rf_data_r2;
        state_d = ST_RD_DONE;
      end
      ST_RD_DONE:  state_d = ST_IDLE;
      ST_WR_ISSUE: state_d = ST_WR_DONE;
      ST_WR_DONE:  state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so they come straight off flops.
    rf_read_d    = (state_d == ST_RD_ISSUE) || (state_d == ST_RD_CAPT);
    rf_write_d   = (state_d == ST_WR_ISSUE) && !is_zero_reg(wa_d);
    opnd_valid_d = (state_d == ST_RD_DONE);
    wb_ack_d     = (state_d == ST_WR_DONE);
    busy_d       = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      rs1_q        <= '0;
      rs2_q        <= '0;
      wa_q         <= '0;
      wd_q         <= '0;
      opnd1_q      <= '0;
      opnd2_q      <= '0;
      rf_read_q    <= 1'b0;
      rf_write_q   <= 1'b0;
      opnd_valid_q <= 1'b0;
      wb_ack_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      wa_q         <= wa_d;
      wd_q         <= wd_d;
      opnd1_q      <= opnd1_d;
      opnd2_q      <= opnd2_d;
      rf_read_q    <= rf_read_d;
      rf_write_q   <= rf_write_d;
      opnd_valid_q <= opnd_valid_d;
      wb_ack_q     <= wb_ack_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.opnd1      = opnd1_q;
  assign bus.opnd2      = opnd2_q;
  assign bus.opnd_valid = opnd_valid_q;
  assign bus.wb_ack     = wb_ack_q;
  assign bus.busy       = busy_q;
  assign bus.rf_read    = rf_read_q;
  assign bus.rf_write   = rf_write_q;
  assign bus.rf_addr_r1 = rs1_q;
  assign bus.rf_addr_r2 = rs2_q;
  assign bus.rf_addr_w  = wa_q;
  assign bus.rf_data_w  = wd_q;

endmodule

// File: tb/tb_rf_access_ctrl.sv
// Bench for rf_access_ctrl: a 32x32 register file responds on the RF side,
// a transaction-level model (expected register contents + fixed latencies) checks results.
// Directed scenarios first, then randomized writes/fetches.
module tb_rf_access_ctrl;
  import rf_access_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  rf_access_ctrl_if bus();

  rf_access_ctrl u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- register file responder ----------------
  data_t rf_mem [32];
  logic  rf_clr;

  always @(posedge clk) begin
    if (rf_clr) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= '0;
    end else if (bus.rf_write) begin
      rf_mem[bus.rf_addr_w] <= bus.rf_data_w;
    end
  end

  assign bus.rf_data_r1 = (bus.rf_read && !bus.rf_write) ? rf_mem[bus.rf_addr_r1] : 'z;
  assign bus.rf_data_r2 = (bus.rf_read && !bus.rf_write) ? rf_mem[bus.rf_addr_r2] : 'z;

  // ---------------- reference model ----------------
  data_t  mdl [32];
  data_t  exp_o1, exp_o2;
  raddr_t last_r1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_check();
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("opnd1_hold", bus.opnd1, exp_o1);
    chk("opnd2_hold", bus.opnd2, exp_o2);
    chk("r1_addr_hold", 32'(bus.rf_addr_r1), 32'(last_r1));
  endtask

  task automatic do_write(input raddr_t a, input data_t d);
    int ack_c;
    int wr_n;
    ack_c = -1;
    wr_n  = 0;
    bus.wb_req  = 1'b1;
    bus.wb_addr = a;
    bus.wb_data = d;
    for (int c = 1; c <= 8; c++) begin
      tick();
      bus.wb_addr = raddr_t'($urandom);
      bus.wb_data = $urandom;
      chk("rd_during_wr", 32'(bus.rf_read), 32'd0);
      if (bus.rf_write) begin
        wr_n++;
        chk("wr_cycle", c, 32'd1);
        chk("wr_addr", 32'(bus.rf_addr_w), 32'(a));
        chk("wr_data", bus.rf_data_w, d);
      end
      if (bus.wb_ack) begin
        ack_c = c;
        break;
      end
    end
    bus.wb_req = 1'b0;
    chk("wb_ack_lat", ack_c, 32'd2);
    chk("wr_pulses", wr_n, (a == 0) ? 32'd0 : 32'd1);
    if (a != 0) mdl[a] = d;
    tick();
    chk("wb_ack_one_cycle", 32'(bus.wb_ack), 32'd0);
  endtask

  // pulse_mode: drop the request after acceptance and re-pulse it while busy.
  task automatic do_fetch(input raddr_t r1, input raddr_t r2, input bit pulse_mode);
    int vld_c;
    int nvld;
    int rd_n;
    vld_c = -1;
    nvld  = 0;
    rd_n  = 0;
    bus.op_req   = 1'b1;
    bus.rs1_addr = r1;
    bus.rs2_addr = r2;
    exp_o1 = mdl[r1];
    exp_o2 = mdl[r2];
    for (int c = 1; c <= 8; c++) begin
      tick();
      bus.rs1_addr = raddr_t'($urandom);
      bus.rs2_addr = raddr_t'($urandom);
      if (pulse_mode) begin
        if (c == 1) bus.op_req = 1'b0;
        if (c == 2) bus.op_req = 1'b1;
        if (c == 3) bus.op_req = 1'b0;
      end
      chk("wr_during_rd", 32'(bus.rf_write), 32'd0);
      if (bus.rf_read) rd_n++;
      if (bus.opnd_valid) begin
        nvld++;
        if (vld_c < 0) begin
          vld_c = c;
          chk("opnd1", bus.opnd1, exp_o1);
          chk("opnd2", bus.opnd2, exp_o2);
          bus.op_req = 1'b0;
        end
        if (!pulse_mode) break;
      end
    end
    bus.op_req = 1'b0;
    chk("opnd_valid_lat", vld_c, 32'd3);
    chk("rd_strobe_cycles", rd_n, 32'd2);
    if (pulse_mode) chk("opnd_valid_count", nvld, 32'd1);
    last_r1 = r1;
    if (!pulse_mode) tick();
  endtask

  // Write and fetch requested in the same cycle; fetch held until served.
  task automatic do_both(input raddr_t wa, input data_t wd, input raddr_t r1, input raddr_t r2);
    int ack_c;
    int vld_c;
    ack_c = -1;
    vld_c = -1;
    bus.wb_req   = 1'b1;
    bus.wb_addr  = wa;
    bus.wb_data  = wd;
    bus.op_req   = 1'b1;
    bus.rs1_addr = r1;
    bus.rs2_addr = r2;
    if (wa != 0) mdl[wa] = wd;
    exp_o1 = mdl[r1];
    exp_o2 = mdl[r2];
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (bus.wb_ack && ack_c < 0) begin
        ack_c = c;
        bus.wb_req = 1'b0;
      end
      if (bus.opnd_valid) begin
        vld_c = c;
        chk("both_opnd1", bus.opnd1, exp_o1);
        chk("both_opnd2", bus.opnd2, exp_o2);
        break;
      end
    end
    bus.wb_req = 1'b0;
    bus.op_req = 1'b0;
    chk("both_ack_lat", ack_c, 32'd2);
    chk("both_vld_lat", vld_c, 32'd6);
    last_r1 = r1;
    tick();
  endtask

  // Reset asserted while the fetch sits in the capture cycle.
  task automatic do_abort(input raddr_t r1, input raddr_t r2);
    int nvld;
    int nwr;
    nvld = 0;
    nwr  = 0;
    bus.op_req   = 1'b1;
    bus.rs1_addr = r1;
    bus.rs2_addr = r2;
    tick();
    tick();
    chk("abort_in_capt_read", 32'(bus.rf_read), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_rf_read", 32'(bus.rf_read), 32'd0);
    chk("abort_opnd1", bus.opnd1, 32'd0);
    chk("abort_opnd2", bus.opnd2, 32'd0);
    chk("abort_addr_r1", 32'(bus.rf_addr_r1), 32'd0);
    chk("abort_data_w", bus.rf_data_w, 32'd0);
    bus.op_req = 1'b0;
    #1 rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (bus.opnd_valid) nvld++;
      if (bus.rf_write) nwr++;
    end
    chk("abort_no_valid", nvld, 32'd0);
    chk("abort_no_write", nwr, 32'd0);
    exp_o1  = '0;
    exp_o2  = '0;
    last_r1 = '0;
  endtask

  initial begin
    rst_n        = 1'b0;
    rf_clr       = 1'b1;
    bus.op_req   = 1'b0;
    bus.rs1_addr = '0;
    bus.rs2_addr = '0;
    bus.wb_req   = 1'b0;
    bus.wb_addr  = '0;
    bus.wb_data  = '0;
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    exp_o1  = '0;
    exp_o2  = '0;
    last_r1 = '0;

    tick();
    tick();
    tick();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_rf_read", 32'(bus.rf_read), 32'd0);
    chk("rst_rf_write", 32'(bus.rf_write), 32'd0);
    chk("rst_opnd_valid", 32'(bus.opnd_valid), 32'd0);
    chk("rst_wb_ack", 32'(bus.wb_ack), 32'd0);
    chk("rst_opnd1", bus.opnd1, 32'd0);
    chk("rst_addr_w", 32'(bus.rf_addr_w), 32'd0);
    #3;
    rst_n  = 1'b1;
    rf_clr = 1'b0;
    tick();

    // directed scenarios
    idle_check();
    do_write(5'd5, 32'hDEADBEEF);
    do_fetch(5'd5, 5'd0, 1'b0);
    chk("dir_opnd1_deadbeef", bus.opnd1, 32'hDEADBEEF);
    chk("dir_opnd2_zero", bus.opnd2, 32'd0);
    do_write(5'd0, 32'h12345678);
    do_fetch(5'd0, 5'd5, 1'b0);
    chk("dir_r0_zero", bus.opnd1, 32'd0);
    do_both(5'd7, 32'hA5A5A5A5, 5'd7, 5'd5);
    chk("dir_raw_a5", bus.opnd1, 32'hA5A5A5A5);
    do_abort(5'd5, 5'd7);
    idle_check();
    do_fetch(5'd5, 5'd7, 1'b0);
    do_fetch(5'd7, 5'd5, 1'b1);
    idle_check();

    // randomized traffic
    for (int it = 0; it < 60; it++) begin
      raddr_t a;
      raddr_t b;
      int     kind;
      kind = int'($urandom_range(0, 4));
      a = ($urandom_range(0, 7) == 0) ? 5'd0 : raddr_t'($urandom_range(0, 31));
      b = raddr_t'($urandom_range(0, 31));
      case (kind)
        0, 1: do_write(a, $urandom);
        2:    do_fetch(a, b, 1'b0);
        3:    do_fetch(b, a, 1'b1);
        default: do_both(a, $urandom, raddr_t'($urandom_range(0, 31)), b);
      endcase
      idle_check();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
